// File: rtl/ibridge_pkg.sv
// Shared types and AXI constants for the instruction-fetch SRAM-to-AXI read bridge.
package ibridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  localparam logic [ID_W-1:0] AXI_ID         = 4'd0;
  localparam logic [7:0]      AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0]      AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]      AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_axi_bridge.sv
// Single-outstanding SRAM-like instruction port to AXI read channel bridge.
// Define INST_BRIDGE_CANCEL_EN to honour fetch-stage flushes (cancel).
module inst_axi_bridge
  import ibridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              cancel,
  output logic              inst_err,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cancel_q, cancel_d;
  logic              cancel_hit;
  logic              drop;
  logic              unused_inputs;

  // Writes are never issued on the fetch port; ID is fixed so rid carries nothing.
  assign unused_inputs = ^{inst_wr, inst_wdata, rid};

`ifdef INST_BRIDGE_CANCEL_EN
  assign cancel_hit = cancel;
`else
  logic unused_cancel;
  assign cancel_hit    = 1'b0;
  assign unused_cancel = cancel;
`endif

  assign arid    = AXI_ID;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};

  // Delivered word passes straight through; otherwise the last delivered word is held.
  assign inst_rdata = inst_data_ok ? rdata : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      rdata_q  <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      rdata_q  <= rdata_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    rdata_d      = rdata_q;
    cancel_d     = cancel_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_err     = 1'b0;
    drop         = cancel_q | cancel_hit;

    case (state_q)
      IDLE: begin
        if (inst_req) begin
          addr_d  = inst_addr;
          size_d  = inst_size;
          state_d = AR;
        end
      end
      AR: begin
        // arvalid stays up until the handshake even if the fetch is flushed.
        arvalid = 1'b1;
        if (cancel_hit) cancel_d = 1'b1;
        if (arready) begin
          inst_addr_ok = 1'b1;
          state_d      = R;
        end
      end
      R: begin
        rready = 1'b1;
        if (cancel_hit) cancel_d = 1'b1;
        if (rvalid && rlast) begin
          if (!drop) begin
            inst_data_ok = 1'b1;
            inst_err     = (rresp != AXI_RESP_OKAY);
            rdata_d      = rdata;
          end
          cancel_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
